lsu_stage: RTL and testbench

Parametrised load/store pipeline stage between execute (p4) and writeback (p5). It replaces the fixed single-cycle memory access with a variable-latency request/acknowledge memory port. It adds a store buffer with store-to-load forwarding and stalls upstream only when a load is outstanding or the buffer is full. Non-memory instructions pass through with one cycle of latency.

---
 rtl/lsu_pkg.sv | 23 ++
 rtl/lsu_store_buffer.sv | 66 ++++++
 rtl/lsu_stage.sv | 151 +++++++++++++++
 tb/tb_lsu_stage.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared widths, FSM encoding and payload structs for the load/store stage.
package lsu_pkg;
  localparam int LSU_DATA_W   = 16;
  localparam int LSU_ADDR_W   = 16;
  localparam int LSU_IDX_W    = 3;
  localparam int LSU_SB_DEPTH = 4;

  typedef enum logic [1:0] {IDLE, LD_WAIT, ST_WAIT} lsu_state_e;

  typedef struct packed {
    logic [LSU_ADDR_W-1:0] addr;
    logic [LSU_DATA_W-1:0] data;
  } sb_entry_t;

  // A load that missed the store buffer, held until its read completes.
  typedef struct packed {
    logic                  vld;
    logic [LSU_ADDR_W-1:0] pc;
    logic [LSU_ADDR_W-1:0] addr;
    logic [LSU_IDX_W-1:0]  idx;
    logic                  wr;
  } ld_pend_t;
endpackage

// File: rtl/lsu_store_buffer.sv
// Circular store FIFO with a parallel youngest-match lookup for forwarding.
module store_buffer import lsu_pkg::*; #(
  parameter int SB_DEPTH = LSU_SB_DEPTH,
  parameter int ADDR_W   = LSU_ADDR_W,
  parameter int DATA_W   = LSU_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  sb_entry_t         push_entry,
  input  logic              pop,
  output sb_entry_t         head,
  output logic              full,
  output logic              empty,
  input  logic [ADDR_W-1:0] lk_addr,
  output logic              hit,
  output logic [DATA_W-1:0] hit_data
);
  localparam int PW = $clog2(SB_DEPTH);

  logic [PW:0]          wp, rp, cnt;
  logic [PW-1:0]        slot;
  logic [SB_DEPTH-1:0]  match;
  sb_entry_t            ent [SB_DEPTH];

  assign cnt   = wp - rp;
  assign full  = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
  assign empty = (wp == rp);
  assign head  = ent[rp[PW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full)  wp <= wp + 1'b1;
      if (pop  && !empty) rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) ent[wp[PW-1:0]] <= push_entry;
  end

  // A slot is live when its distance from the head is below the occupancy.
  for (genvar j = 0; j < SB_DEPTH; j++) begin : g_ent
    localparam logic [PW-1:0] SLOT = PW'(j);
    logic [PW-1:0] off;
    assign off      = SLOT - rp[PW-1:0];
    assign match[j] = ({1'b0, off} < cnt) && (ent[j].addr == lk_addr);
  end

  // Walk oldest to youngest so the youngest matching store wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    slot     = '0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      slot = rp[PW-1:0] + PW'(k);
      if (match[slot]) begin
        hit      = 1'b1;
        hit_data = ent[slot].data;
      end
    end
  end
endmodule

// File: rtl/lsu_stage.sv
// Load/store stage p4->p5: store buffer with forwarding, one outstanding
// request on a variable-latency req/ack memory port.
module lsu_stage import lsu_pkg::*; #(
  parameter int DATA_W   = LSU_DATA_W,
  parameter int ADDR_W   = LSU_ADDR_W,
  parameter int IDX_W    = LSU_IDX_W,
  parameter int SB_DEPTH = LSU_SB_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_p4,
  input  logic [ADDR_W-1:0] pc_p4,
  input  logic              ld_p4,
  input  logic              st_p4,
  input  logic [ADDR_W-1:0] addr_p4,
  input  logic [DATA_W-1:0] wdata_p4,
  input  logic [DATA_W-1:0] dest_value_p4,
  input  logic [IDX_W-1:0]  dest_index_p4,
  input  logic              dest_wr_p4,
  output logic              stall_p4,
  output logic              valid_p5,
  output logic [ADDR_W-1:0] pc_p5,
  output logic [DATA_W-1:0] dest_value_p5,
  output logic [IDX_W-1:0]  dest_index_p5,
  output logic              dest_wr_p5,
  output logic              err_p5,
  output logic              st_err,
  output logic              sb_empty,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_err
);
  lsu_state_e        state, state_nx;
  ld_pend_t          pend;
  sb_entry_t         push_entry, head;
  logic              sb_full, sb_emp, fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic              acc, push, pop, ld_miss, ld_go, ld_done;

  // pend.vld covers both the not-yet-issued and the in-flight load.
  assign stall_p4 = (state == LD_WAIT) | pend.vld | (st_p4 & sb_full);
  assign acc      = valid_p4 & ~stall_p4;
  assign push     = acc & st_p4;
  assign ld_miss  = acc & ld_p4 & ~fwd_hit;
  assign ld_go    = pend.vld | ld_miss;
  assign pop      = (state == ST_WAIT) & mem_ack;
  assign ld_done  = (state == LD_WAIT) & mem_ack;
  assign sb_empty = sb_emp & (state != ST_WAIT);

  assign push_entry.addr = addr_p4;
  assign push_entry.data = wdata_p4;

  store_buffer #(
    .SB_DEPTH (SB_DEPTH),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .full       (sb_full),
    .empty      (sb_emp),
    .lk_addr    (addr_p4),
    .hit        (fwd_hit),
    .hit_data   (fwd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Loads beat store drain; a store ack hands the port straight to a waiting load.
  always_comb begin
    state_nx  = state;
    mem_req   = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state)
      IDLE: begin
        if (ld_go)        state_nx = LD_WAIT;
        else if (!sb_emp) state_nx = ST_WAIT;
      end
      LD_WAIT: begin
        mem_req  = 1'b1;
        mem_addr = pend.addr;
        if (mem_ack) state_nx = IDLE;
      end
      ST_WAIT: begin
        mem_req   = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = head.addr;
        mem_wdata = head.data;
        if (mem_ack) state_nx = ld_go ? LD_WAIT : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
    end else if (ld_miss) begin
      pend.vld  <= 1'b1;
      pend.pc   <= pc_p4;
      pend.addr <= addr_p4;
      pend.idx  <= dest_index_p4;
      pend.wr   <= dest_wr_p4;
    end else if (ld_done) begin
      pend.vld  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_p5      <= 1'b0;
      pc_p5         <= '0;
      dest_value_p5 <= '0;
      dest_index_p5 <= '0;
      dest_wr_p5    <= 1'b0;
      err_p5        <= 1'b0;
      st_err        <= 1'b0;
    end else begin
      valid_p5 <= 1'b0;
      err_p5   <= 1'b0;
      st_err   <= pop & mem_err;
      if (ld_done) begin
        valid_p5      <= 1'b1;
        pc_p5         <= pend.pc;
        dest_value_p5 <= mem_rdata;
        dest_index_p5 <= pend.idx;
        dest_wr_p5    <= pend.wr & ~mem_err;
        err_p5        <= mem_err;
      end else if (acc && !ld_miss) begin
        valid_p5      <= 1'b1;
        pc_p5         <= pc_p4;
        dest_value_p5 <= ld_p4 ? fwd_data : dest_value_p4;
        dest_index_p5 <= dest_index_p4;
        dest_wr_p5    <= dest_wr_p4 & ~st_p4;
      end
    end
  end
endmodule

// File: tb/tb_lsu_stage.sv
// Directed bench for lsu_stage; the bench plays the memory slave by hand.
module tb_lsu_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        valid_p4, ld_p4, st_p4, dest_wr_p4;
  logic [15:0] pc_p4, addr_p4, wdata_p4, dest_value_p4;
  logic [2:0]  dest_index_p4;
  logic        stall_p4, valid_p5, dest_wr_p5, err_p5, st_err, sb_empty;
  logic [15:0] pc_p5, dest_value_p5;
  logic [2:0]  dest_index_p5;
  logic        mem_req, mem_wr, mem_ack, mem_err;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lsu_stage dut (
    .clk(clk), .rst(rst),
    .valid_p4(valid_p4), .pc_p4(pc_p4), .ld_p4(ld_p4), .st_p4(st_p4),
    .addr_p4(addr_p4), .wdata_p4(wdata_p4), .dest_value_p4(dest_value_p4),
    .dest_index_p4(dest_index_p4), .dest_wr_p4(dest_wr_p4),
    .stall_p4(stall_p4), .valid_p5(valid_p5), .pc_p5(pc_p5),
    .dest_value_p5(dest_value_p5), .dest_index_p5(dest_index_p5),
    .dest_wr_p5(dest_wr_p5), .err_p5(err_p5), .st_err(st_err),
    .sb_empty(sb_empty), .mem_req(mem_req), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic nop();
    valid_p4 = 0; ld_p4 = 0; st_p4 = 0; dest_wr_p4 = 0;
    pc_p4 = '0; addr_p4 = '0; wdata_p4 = '0; dest_value_p4 = '0; dest_index_p4 = '0;
  endtask

  task automatic ins(input logic ld, input logic st, input logic [15:0] a, input logic [15:0] wd,
                     input logic [15:0] dv, input logic [2:0] idx, input logic wr, input logic [15:0] pc);
    valid_p4 = 1; ld_p4 = ld; st_p4 = st; addr_p4 = a; wdata_p4 = wd;
    dest_value_p4 = dv; dest_index_p4 = idx; dest_wr_p4 = wr; pc_p4 = pc;
  endtask

  // Wait (bounded) for a write request, check its payload, then ack it.
  task automatic drain(input string tag, input logic [15:0] a, input logic [15:0] d, input logic e);
    int n = 0;
    @(negedge clk);
    while (!mem_req && n < 16) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_req"}, mem_req, 1);
    chk({tag, "_wr"}, mem_wr, 1);
    chk({tag, "_addr"}, mem_addr, a);
    chk({tag, "_data"}, mem_wdata, d);
    mem_ack = 1; mem_err = e;
    nxt();
    mem_ack = 0; mem_err = 0;
  endtask

  initial begin
    rst = 1; nop(); mem_ack = 0; mem_err = 0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_vld", valid_p5, 0);
    chk("rst_empty", sb_empty, 1);
    chk("rst_req", mem_req, 0);
    chk("rst_stall", stall_p4, 0);
    chk("rst_sterr", st_err, 0);
    nxt(); rst = 0;

    // ALU pass-through
    ins(0, 0, 16'h0000, 16'h0000, 16'h1234, 3'd5, 1, 16'h0100);
    @(negedge clk); chk("alu_stall", stall_p4, 0);
    nxt(); nop();
    @(negedge clk);
    chk("alu_vld", valid_p5, 1);
    chk("alu_val", dest_value_p5, 16'h1234);
    chk("alu_idx", dest_index_p5, 5);
    chk("alu_wr", dest_wr_p5, 1);
    chk("alu_pc", pc_p5, 16'h0100);
    chk("alu_noreq", mem_req, 0);
    nxt();
    @(negedge clk); chk("alu_one", valid_p5, 0);

    // Forwarding from the youngest of two stores to the same address
    nxt(); ins(0, 1, 16'h0040, 16'hBEEF, 16'h0, 3'd0, 0, 16'h0110);
    nxt(); ins(0, 1, 16'h0040, 16'hCAFE, 16'h0, 3'd0, 0, 16'h0112);
    @(negedge clk);
    chk("st_vld", valid_p5, 1);
    chk("st_wr", dest_wr_p5, 0);
    nxt(); ins(1, 0, 16'h0040, 16'h0, 16'h0, 3'd3, 1, 16'h0114);
    @(negedge clk);
    chk("fw_stall", stall_p4, 0);
    nxt(); nop();
    @(negedge clk);
    chk("fw_vld", valid_p5, 1);
    chk("fw_data", dest_value_p5, 16'hCAFE);
    chk("fw_idx", dest_index_p5, 3);
    chk("fw_noread", {mem_req, mem_wr}, 2'b11);
    chk("fw_wdata", mem_wdata, 16'hBEEF);
    drain("fw_d0", 16'h0040, 16'hBEEF, 0);
    drain("fw_d1", 16'h0040, 16'hCAFE, 0);
    @(negedge clk);
    chk("fw_empty", sb_empty, 1);
    chk("fw_sterr", st_err, 0);

    // Fill the buffer; fifth store stalls until the first write ack
    nxt();
    for (int i = 0; i < 4; i++) begin
      ins(0, 1, 16'h0010 + 16'(i), 16'h1000 + 16'(i), 16'h0, 3'd0, 0, 16'h0120);
      @(negedge clk); chk("fill_nostall", stall_p4, 0);
      nxt();
    end
    ins(0, 1, 16'h0014, 16'h1004, 16'h0, 3'd0, 0, 16'h0128);
    @(negedge clk);
    chk("fill_full", stall_p4, 1);
    chk("fill_head", mem_addr, 16'h0010);
    mem_ack = 1;
    nxt(); mem_ack = 0;
    @(negedge clk);
    chk("fill_release", stall_p4, 0);
    chk("fill_bubble", valid_p5, 0);
    nxt(); nop();
    @(negedge clk); chk("fill_s4_vld", valid_p5, 1);
    for (int i = 1; i < 5; i++)
      drain("fill_d", 16'h0010 + 16'(i), 16'h1000 + 16'(i), 0);

    // Load miss, ack after three waiting cycles
    ins(1, 0, 16'h0080, 16'h0, 16'h0, 3'd2, 1, 16'h0200);
    @(negedge clk); chk("lm_acc", stall_p4, 0);
    nxt(); nop();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("lm_stall", stall_p4, 1);
      chk("lm_req", {mem_req, mem_wr}, 2'b10);
      chk("lm_addr", mem_addr, 16'h0080);
      chk("lm_novld", valid_p5, 0);
      nxt();
    end
    @(negedge clk);
    chk("lm_stall", stall_p4, 1);
    mem_ack = 1; mem_rdata = 16'h00A5;
    nxt(); mem_ack = 0; mem_rdata = '0;
    @(negedge clk);
    chk("lm_vld", valid_p5, 1);
    chk("lm_val", dest_value_p5, 16'h00A5);
    chk("lm_idx", dest_index_p5, 2);
    chk("lm_wr", dest_wr_p5, 1);
    chk("lm_err", err_p5, 0);
    chk("lm_pc", pc_p5, 16'h0200);
    chk("lm_unstall", stall_p4, 0);

    // Load arriving while a store is in flight
    nxt(); ins(0, 1, 16'h0030, 16'h0123, 16'h0, 3'd0, 0, 16'h0210);
    nxt(); ins(0, 1, 16'h0031, 16'h0456, 16'h0, 3'd0, 0, 16'h0212);
    nxt(); ins(1, 0, 16'h0090, 16'h0, 16'h0, 3'd4, 1, 16'h0214);
    @(negedge clk);
    chk("lst_acc", stall_p4, 0);
    chk("lst_wr", mem_wr, 1);
    nxt(); nop();
    @(negedge clk);
    chk("lst_stall", stall_p4, 1);
    chk("lst_waddr", mem_addr, 16'h0030);
    chk("lst_novld", valid_p5, 0);
    mem_ack = 1;
    nxt(); mem_ack = 0;
    @(negedge clk);
    chk("lst_rd", {mem_req, mem_wr}, 2'b10);
    chk("lst_raddr", mem_addr, 16'h0090);
    mem_ack = 1; mem_rdata = 16'h5A5A;
    nxt(); mem_ack = 0; mem_rdata = '0;
    @(negedge clk);
    chk("lst_vld", valid_p5, 1);
    chk("lst_val", dest_value_p5, 16'h5A5A);
    chk("lst_idx", dest_index_p5, 4);
    chk("lst_norq", mem_req, 0);
    nxt();
    @(negedge clk);
    chk("lst_drain", {mem_req, mem_wr}, 2'b11);
    chk("lst_daddr", mem_addr, 16'h0031);
    mem_ack = 1;
    nxt(); mem_ack = 0;

    // Load fault
    ins(1, 0, 16'h00A0, 16'h0, 16'h0, 3'd6, 1, 16'h0240);
    nxt(); nop();
    @(negedge clk);
    chk("lf_req", {mem_req, mem_wr}, 2'b10);
    mem_ack = 1; mem_err = 1; mem_rdata = 16'hDEAD;
    nxt(); mem_ack = 0; mem_err = 0; mem_rdata = '0;
    @(negedge clk);
    chk("lf_vld", valid_p5, 1);
    chk("lf_err", err_p5, 1);
    chk("lf_wr", dest_wr_p5, 0);
    chk("lf_val", dest_value_p5, 16'hDEAD);
    nxt();
    @(negedge clk);
    chk("lf_errclr", err_p5, 0);
    chk("lf_vldclr", valid_p5, 0);

    // Store fault
    nxt(); ins(0, 1, 16'h0050, 16'h7777, 16'h0, 3'd0, 0, 16'h0250);
    nxt(); nop();
    drain("sf", 16'h0050, 16'h7777, 1);
    @(negedge clk); chk("sf_pulse", st_err, 1);
    nxt();
    @(negedge clk);
    chk("sf_clr", st_err, 0);
    chk("sf_empty", sb_empty, 1);

    // Reset while a load waits and a store is buffered
    nxt(); ins(0, 1, 16'h0060, 16'h1111, 16'h0, 3'd0, 0, 16'h0260);
    nxt(); ins(1, 0, 16'h0070, 16'h0, 16'h0, 3'd1, 1, 16'h0262);
    nxt(); nop();
    @(negedge clk);
    chk("rl_req", {mem_req, mem_wr}, 2'b10);
    chk("rl_nempty", sb_empty, 0);
    rst = 1;
    nxt();
    @(negedge clk);
    chk("rl_vld", valid_p5, 0);
    chk("rl_val", dest_value_p5, 0);
    chk("rl_pc", pc_p5, 0);
    chk("rl_req0", mem_req, 0);
    chk("rl_stall", stall_p4, 0);
    chk("rl_empty", sb_empty, 1);
    rst = 0;
    nxt(); nxt();
    @(negedge clk);
    chk("rl_discard", mem_req, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "timeout");
  end
endmodule
